// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pkg
//  Description : Shared constants for the multicycle MIPS control unit:
//                FSM state encodings, opcode/funct fields, ALU codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

   // FSM state encodings (4-bit State register)
   localparam logic [3:0] FETCH    = 4'd0;
   localparam logic [3:0] DECODE   = 4'd1;
   localparam logic [3:0] MEMADR   = 4'd2;
   localparam logic [3:0] MEMREAD  = 4'd3;
   localparam logic [3:0] MEMWB    = 4'd4;
   localparam logic [3:0] MEMWRITE = 4'd5;
   localparam logic [3:0] EXECUTE  = 4'd6;
   localparam logic [3:0] ALUWB    = 4'd7;
   localparam logic [3:0] BRANCH   = 4'd8;
   localparam logic [3:0] ADDIEX   = 4'd9;
   localparam logic [3:0] ADDIWB   = 4'd10;
   localparam logic [3:0] JUMP     = 4'd11;

   // Opcodes (IR[31:26])
   localparam logic [5:0] c_op_rtype = 6'b000000;
   localparam logic [5:0] c_op_lw    = 6'b100011;
   localparam logic [5:0] c_op_sw    = 6'b101011;
   localparam logic [5:0] c_op_beq   = 6'b000100;
   localparam logic [5:0] c_op_addi  = 6'b001000;
   localparam logic [5:0] c_op_j     = 6'b000010;

   // R-type function fields (IR[5:0])
   localparam logic [5:0] c_funct_add = 6'b100000;
   localparam logic [5:0] c_funct_sub = 6'b100010;
   localparam logic [5:0] c_funct_and = 6'b100100;
   localparam logic [5:0] c_funct_or  = 6'b100101;
   localparam logic [5:0] c_funct_slt = 6'b101010;

   // ALUControl codes
   localparam logic [2:0] c_alu_add = 3'b010;
   localparam logic [2:0] c_alu_sub = 3'b110;
   localparam logic [2:0] c_alu_and = 3'b000;
   localparam logic [2:0] c_alu_or  = 3'b001;
   localparam logic [2:0] c_alu_slt = 3'b111;

   // ALUOp: how the ALU decoder should pick its operation
   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

endpackage : ctrl_pkg
`default_nettype wire

// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_if
//  Description : Bundle between the control unit and the multicycle
//                datapath: instruction fields and status in, control out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_control_if;

   // Datapath -> control
   logic [5:0] Op;
   logic [5:0] Funct;
   logic       Zero;
   logic       MemReady;

   // Control -> datapath
   logic       IorD;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegDst;
   logic       MemtoReg;
   logic       RegWrite;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [2:0] ALUControl;
   logic [1:0] PCSrc;
   logic       PCEn;

   // Control unit side
   modport master (
      input  Op, Funct, Zero, MemReady,
      output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
             ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn
   );

   // Datapath side
   modport slave (
      output Op, Funct, Zero, MemReady,
      input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
             ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn
   );

endinterface : multicycle_control_if
`default_nettype wire

// File: rtl/multicycle_control_alu_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : alu_decoder
//  Description : Combinational ALU operation decoder. Maps ALUOp and the
//                R-type Funct field to a 3-bit ALUControl code and flags
//                whether Funct is one of the supported operations.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder
   import ctrl_pkg::*;
(
   input  logic [1:0] ALUOp,
   input  logic [5:0] Funct,
   output logic [2:0] ALUControl,
   output logic       FunctValid
);

   logic [2:0] w_funct_ctrl;

   // Funct field lookup, independent of ALUOp so DECODE can test legality
   always_comb begin
      w_funct_ctrl = c_alu_add;
      FunctValid   = 1'b1;
      case (Funct)
         c_funct_add: w_funct_ctrl = c_alu_add;
         c_funct_sub: w_funct_ctrl = c_alu_sub;
         c_funct_and: w_funct_ctrl = c_alu_and;
         c_funct_or:  w_funct_ctrl = c_alu_or;
         c_funct_slt: w_funct_ctrl = c_alu_slt;
         default:     FunctValid   = 1'b0;
      endcase
   end

   // Select forced add/sub or the Funct-derived operation
   always_comb begin
      ALUControl = c_alu_add;
      case (ALUOp)
         ALUOP_ADD:   ALUControl = c_alu_add;
         ALUOP_SUB:   ALUControl = c_alu_sub;
         ALUOP_FUNCT: ALUControl = w_funct_ctrl;
         default:     ALUControl = c_alu_add;
      endcase
   end

endmodule : alu_decoder
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Moore control FSM for the shared-memory multicycle MIPS
//                datapath. Sequences fetch/decode/execute with MemReady
//                wait states, drives datapath enables and selects, flags
//                unsupported instructions and counts retired instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
   import ctrl_pkg::*;
#(
   parameter bit ENABLE_ADDI = 1'b1,
   parameter bit ENABLE_JUMP = 1'b1,
   parameter int CNT_W       = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   multicycle_control_if.master bus,
   output logic                 IllegalOp,
   output logic [CNT_W-1:0]     Retired,
   output logic [3:0]           State
);

   localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [3:0]       r_state;
   logic [3:0]       w_next_state;
   logic [CNT_W-1:0] r_retired;
   logic             w_retire;
   logic             w_op_legal;
   logic             w_funct_valid;
   aluop_t           w_aluop;
   logic [2:0]       w_alucontrol;

   logic             w_iord;
   logic             w_memwrite;
   logic             w_irwrite;
   logic             w_regdst;
   logic             w_memtoreg;
   logic             w_regwrite;
   logic             w_alusrca;
   logic [1:0]       w_alusrcb;
   logic [1:0]       w_pcsrc;
   logic             w_pcen;
   logic             w_illegal;

   alu_decoder u_alu_decoder (
      .ALUOp      (w_aluop),
      .Funct      (bus.Funct),
      .ALUControl (w_alucontrol),
      .FunctValid (w_funct_valid)
   );

   // Classify the current opcode as supported or not
   always_comb begin
      w_op_legal = 1'b0;
      case (bus.Op)
         c_op_lw, c_op_sw, c_op_beq: w_op_legal = 1'b1;
         c_op_rtype:                 w_op_legal = w_funct_valid;
         c_op_addi:                  w_op_legal = ENABLE_ADDI;
         c_op_j:                     w_op_legal = ENABLE_JUMP;
         default:                    w_op_legal = 1'b0;
      endcase
   end

   // Next-state logic; unused encodings recover to FETCH
   always_comb begin
      w_next_state = FETCH;
      case (r_state)
         FETCH:    w_next_state = bus.MemReady ? DECODE : FETCH;
         DECODE: begin
            w_next_state = FETCH;
            if (w_op_legal) begin
               case (bus.Op)
                  c_op_lw, c_op_sw: w_next_state = MEMADR;
                  c_op_rtype:       w_next_state = EXECUTE;
                  c_op_beq:         w_next_state = BRANCH;
                  c_op_addi:        w_next_state = ADDIEX;
                  c_op_j:           w_next_state = JUMP;
                  default:          w_next_state = FETCH;
               endcase
            end
         end
         MEMADR:   w_next_state = (bus.Op == c_op_lw) ? MEMREAD : MEMWRITE;
         MEMREAD:  w_next_state = bus.MemReady ? MEMWB : MEMREAD;
         MEMWB:    w_next_state = FETCH;
         MEMWRITE: w_next_state = bus.MemReady ? FETCH : MEMWRITE;
         EXECUTE:  w_next_state = ALUWB;
         ALUWB:    w_next_state = FETCH;
         BRANCH:   w_next_state = FETCH;
         ADDIEX:   w_next_state = ADDIWB;
         ADDIWB:   w_next_state = FETCH;
         JUMP:     w_next_state = FETCH;
         default:  w_next_state = FETCH;
      endcase
   end

   // An instruction retires on leaving its last state
   always_comb begin
      w_retire = 1'b0;
      case (r_state)
         MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: w_retire = 1'b1;
         MEMWRITE:                           w_retire = bus.MemReady;
         default:                            w_retire = 1'b0;
      endcase
   end

   // State register; reset aborts any instruction in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= FETCH;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Retired-instruction counter, wraps naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_retired <= '0;
      end else if (w_retire) begin
         r_retired <= r_retired + c_one;
      end
   end

   // Moore output decode; PCEn also looks at Zero/MemReady
   always_comb begin
      w_iord     = 1'b0;
      w_memwrite = 1'b0;
      w_irwrite  = 1'b0;
      w_regdst   = 1'b0;
      w_memtoreg = 1'b0;
      w_regwrite = 1'b0;
      w_alusrca  = 1'b0;
      w_alusrcb  = 2'b00;
      w_aluop    = ALUOP_ADD;
      w_pcsrc    = 2'b00;
      w_pcen     = 1'b0;
      w_illegal  = 1'b0;
      case (r_state)
         FETCH: begin
            w_alusrcb = 2'b01;
            w_irwrite = bus.MemReady;
            w_pcen    = bus.MemReady;
         end
         DECODE: begin
            w_alusrcb = 2'b11;
            w_illegal = ~w_op_legal;
         end
         MEMADR: begin
            w_alusrca = 1'b1;
            w_alusrcb = 2'b10;
         end
         MEMREAD: begin
            w_iord = 1'b1;
         end
         MEMWB: begin
            w_memtoreg = 1'b1;
            w_regwrite = 1'b1;
         end
         MEMWRITE: begin
            w_iord     = 1'b1;
            w_memwrite = 1'b1;
         end
         EXECUTE: begin
            w_alusrca = 1'b1;
            w_aluop   = ALUOP_FUNCT;
         end
         ALUWB: begin
            w_regdst   = 1'b1;
            w_regwrite = 1'b1;
         end
         BRANCH: begin
            w_alusrca = 1'b1;
            w_aluop   = ALUOP_SUB;
            w_pcsrc   = 2'b01;
            w_pcen    = bus.Zero;
         end
         ADDIEX: begin
            w_alusrca = 1'b1;
            w_alusrcb = 2'b10;
         end
         ADDIWB: begin
            w_regwrite = 1'b1;
         end
         JUMP: begin
            w_pcsrc = 2'b10;
            w_pcen  = 1'b1;
         end
         default: ;
      endcase
   end

   // Write enables are held low for as long as reset is asserted
   assign bus.MemWrite   = w_memwrite & rst_n;
   assign bus.IRWrite    = w_irwrite  & rst_n;
   assign bus.RegWrite   = w_regwrite & rst_n;
   assign bus.PCEn       = w_pcen     & rst_n;
   assign IllegalOp      = w_illegal  & rst_n;

   assign bus.IorD       = w_iord;
   assign bus.RegDst     = w_regdst;
   assign bus.MemtoReg   = w_memtoreg;
   assign bus.ALUSrcA    = w_alusrca;
   assign bus.ALUSrcB    = w_alusrcb;
   assign bus.ALUControl = w_alucontrol;
   assign bus.PCSrc      = w_pcsrc;

   assign Retired        = r_retired;
   assign State          = r_state;

endmodule : multicycle_control
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control
//  Description : Self-checking bench for multicycle_control. Three instances
//                share one stimulus stream: default build, CNT_W = 4 and
//                ENABLE_JUMP = 0. Expected behaviour comes from an
//                instruction-level model (state path per instruction).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       mr;

   logic        ill0, ill4, illnj;
   logic [15:0] ret0;
   logic [3:0]  ret4;
   logic [15:0] retnj;
   logic [3:0]  st0, st4, stnj;

   int checks = 0;
   int passed = 0;
   int exp_retired = 0;

   multicycle_control_if bus0 ();
   multicycle_control_if bus4 ();
   multicycle_control_if busnj ();

   assign bus0.Op  = op;  assign bus0.Funct  = funct; assign bus0.Zero  = zero; assign bus0.MemReady  = mr;
   assign bus4.Op  = op;  assign bus4.Funct  = funct; assign bus4.Zero  = zero; assign bus4.MemReady  = mr;
   assign busnj.Op = op;  assign busnj.Funct = funct; assign busnj.Zero = zero; assign busnj.MemReady = mr;

   multicycle_control #(.CNT_W(16)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0), .IllegalOp(ill0), .Retired(ret0), .State(st0));
   multicycle_control #(.CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .bus(bus4), .IllegalOp(ill4), .Retired(ret4), .State(st4));
   multicycle_control #(.ENABLE_JUMP(1'b0), .CNT_W(16)) dutnj (
      .clk(clk), .rst_n(rst_n), .bus(busnj), .IllegalOp(illnj), .Retired(retnj), .State(stnj));

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic int funct_alu(input logic [5:0] f);
      case (f)
         6'b100000: return 2;  // add 010
         6'b100010: return 6;  // sub 110
         6'b100100: return 0;  // and 000
         6'b100101: return 1;  // or  001
         6'b101010: return 7;  // slt 111
         default:   return -1;
      endcase
   endfunction

   function automatic bit is_legal(input logic [5:0] o, input logic [5:0] f, input bit en_j);
      if (o == 6'b000000) return funct_alu(f) >= 0;
      if (o == 6'b100011 || o == 6'b101011 || o == 6'b000100 || o == 6'b001000) return 1'b1;
      if (o == 6'b000010) return en_j;
      return 1'b0;
   endfunction

   // {IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUControl,PCSrc,PCEn,IllegalOp}
   function automatic logic [15:0] exp_vec(input logic [3:0] st, input logic [5:0] o,
                                           input logic [5:0] f, input logic z, input logic m);
      logic iord, mw, irw, rd, m2r, rw, sa, pe, ill;
      logic [1:0] sb, ps;
      logic [2:0] ac;
      iord = 0; mw = 0; irw = 0; rd = 0; m2r = 0; rw = 0; sa = 0; pe = 0; ill = 0;
      sb = 2'b00; ps = 2'b00; ac = 3'b010;
      case (st)
         4'd0:  begin sb = 2'b01; irw = m; pe = m; end
         4'd1:  begin sb = 2'b11; ill = !is_legal(o, f, 1'b1); end
         4'd2:  begin sa = 1; sb = 2'b10; end
         4'd3:  iord = 1;
         4'd4:  begin m2r = 1; rw = 1; end
         4'd5:  begin iord = 1; mw = 1; end
         4'd6:  begin sa = 1; ac = 3'(funct_alu(f)); end
         4'd7:  begin rd = 1; rw = 1; end
         4'd8:  begin sa = 1; ac = 3'b110; ps = 2'b01; pe = z; end
         4'd9:  begin sa = 1; sb = 2'b10; end
         4'd10: rw = 1;
         4'd11: begin ps = 2'b10; pe = 1; end
         default: ;
      endcase
      return {iord, mw, irw, rd, m2r, rw, sa, sb, ac, ps, pe, ill};
   endfunction

   function automatic logic [15:0] dut_vec();
      return {bus0.IorD, bus0.MemWrite, bus0.IRWrite, bus0.RegDst, bus0.MemtoReg,
              bus0.RegWrite, bus0.ALUSrcA, bus0.ALUSrcB, bus0.ALUControl,
              bus0.PCSrc, bus0.PCEn, ill0};
   endfunction

   // Run one instruction through dut0/dut4 and check every cycle of it
   task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                            input int fstall, input int mstall);
      logic [3:0] sq[$];
      logic       mq[$];
      logic [15:0] ev;
      bit legal;
      legal = is_legal(o, f, 1'b1);
      repeat (fstall) begin sq.push_back(4'd0); mq.push_back(1'b0); end
      sq.push_back(4'd0); mq.push_back(1'b1);
      sq.push_back(4'd1); mq.push_back(1'($urandom));
      if (legal) begin
         case (o)
            6'b100011: begin
               sq.push_back(4'd2); mq.push_back(1'($urandom));
               repeat (mstall) begin sq.push_back(4'd3); mq.push_back(1'b0); end
               sq.push_back(4'd3); mq.push_back(1'b1);
               sq.push_back(4'd4); mq.push_back(1'($urandom));
            end
            6'b101011: begin
               sq.push_back(4'd2); mq.push_back(1'($urandom));
               repeat (mstall) begin sq.push_back(4'd5); mq.push_back(1'b0); end
               sq.push_back(4'd5); mq.push_back(1'b1);
            end
            6'b000000: begin
               sq.push_back(4'd6); mq.push_back(1'($urandom));
               sq.push_back(4'd7); mq.push_back(1'($urandom));
            end
            6'b000100: begin sq.push_back(4'd8); mq.push_back(1'($urandom)); end
            6'b001000: begin
               sq.push_back(4'd9);  mq.push_back(1'($urandom));
               sq.push_back(4'd10); mq.push_back(1'($urandom));
            end
            default:   begin sq.push_back(4'd11); mq.push_back(1'($urandom)); end
         endcase
      end
      for (int i = 0; i < sq.size(); i++) begin
         @(negedge clk);
         op = o; funct = f; zero = z; mr = mq[i];
         #1;
         checks++;
         if (st0 !== sq[i]) $display("FAIL state op=%b cyc=%0d got %0d want %0d", o, i, st0, sq[i]);
         else passed++;
         ev = exp_vec(sq[i], o, f, z, mq[i]);
         checks++;
         if (dut_vec() !== ev) $display("FAIL ctrl op=%b funct=%b st=%0d got %b want %b", o, f, sq[i], dut_vec(), ev);
         else passed++;
         checks++;
         if (ret0 !== 16'(exp_retired)) $display("FAIL retired_hold got %0d want %0d", ret0, 16'(exp_retired));
         else passed++;
      end
      if (legal) exp_retired++;
   endtask

   // One idle FETCH cycle checking the counters after the last instruction
   task automatic idle_check(input string tag);
      @(negedge clk);
      mr = 1'b0;
      #1;
      checks++;
      if (st0 !== 4'd0) $display("FAIL %s idle_state got %0d want 0", tag, st0);
      else passed++;
      checks++;
      if (ret0 !== 16'(exp_retired)) $display("FAIL %s retired got %0d want %0d", tag, ret0, 16'(exp_retired));
      else passed++;
      checks++;
      if (ret4 !== 4'(exp_retired)) $display("FAIL %s retired_w4 got %0d want %0d", tag, ret4, 4'(exp_retired));
      else passed++;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0; mr = 1'b1; op = 6'b000000; funct = 6'b100000; zero = 1'b1;
      #1;
      checks++;
      if (st0 !== 4'd0) $display("FAIL reset_state got %0d want 0", st0); else passed++;
      checks++;
      if (ret0 !== 16'd0) $display("FAIL reset_retired got %0d want 0", ret0); else passed++;
      checks++;
      if ({bus0.IRWrite, bus0.PCEn, bus0.MemWrite, bus0.RegWrite, ill0} !== 5'b0)
         $display("FAIL reset_enables got %b want 00000",
                  {bus0.IRWrite, bus0.PCEn, bus0.MemWrite, bus0.RegWrite, ill0});
      else passed++;
      @(negedge clk);
      rst_n = 1'b1; mr = 1'b0;
      exp_retired = 0;
   endtask

   task automatic test_rtype();
      run_instr(6'b000000, 6'b100000, 1'b0, 0, 0);
      run_instr(6'b000000, 6'b101010, 1'b0, 1, 0);
      idle_check("rtype");
   endtask

   task automatic test_lw_stall();
      run_instr(6'b100011, 6'b000000, 1'b0, 0, 2);
      idle_check("lw");
   endtask

   task automatic test_beq();
      run_instr(6'b000100, 6'b000000, 1'b1, 0, 0);
      run_instr(6'b000100, 6'b000000, 1'b0, 0, 0);
      idle_check("beq");
   endtask

   task automatic test_illegal();
      run_instr(6'b111111, 6'b000000, 1'b0, 0, 0);
      run_instr(6'b000000, 6'b000111, 1'b0, 0, 0);
      idle_check("illegal");
   endtask

   task automatic test_reset_mid_sw();
      test_reset();
      @(negedge clk); op = 6'b101011; mr = 1'b1;   // FETCH
      @(negedge clk); mr = 1'b0;                   // DECODE
      @(negedge clk);                              // MEMADR
      @(negedge clk);                              // MEMWRITE, stalled
      #1;
      checks++;
      if (st0 !== 4'd5 || bus0.MemWrite !== 1'b1)
         $display("FAIL sw_pre_reset state/memwrite got %0d/%b want 5/1", st0, bus0.MemWrite);
      else passed++;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus0.MemWrite !== 1'b0) $display("FAIL sw_abort_memwrite got %b want 0", bus0.MemWrite); else passed++;
      checks++;
      if (st0 !== 4'd0) $display("FAIL sw_abort_state got %0d want 0", st0); else passed++;
      checks++;
      if (ret0 !== 16'd0) $display("FAIL sw_abort_retired got %0d want 0", ret0); else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      exp_retired = 0;
      idle_check("sw_abort");
   endtask

   task automatic test_jump_disabled();
      test_reset();
      @(negedge clk); op = 6'b000010; funct = 6'b000000; mr = 1'b1;  // FETCH
      @(negedge clk); mr = 1'b0;                                     // DECODE
      #1;
      checks++;
      if (illnj !== 1'b1 || ill0 !== 1'b0)
         $display("FAIL nojump_illegal got nj=%b main=%b want 1/0", illnj, ill0);
      else passed++;
      @(negedge clk);
      #1;
      checks++;
      if (stnj !== 4'd0 || st0 !== 4'd11)
         $display("FAIL nojump_state got nj=%0d main=%0d want 0/11", stnj, st0);
      else passed++;
      @(negedge clk);
      #1;
      checks++;
      if (retnj !== 16'd0 || ret0 !== 16'd1)
         $display("FAIL nojump_retired got nj=%0d main=%0d want 0/1", retnj, ret0);
      else passed++;
      test_reset();
   endtask

   task automatic test_wrap();
      test_reset();
      for (int i = 0; i < 17; i++) run_instr(6'b000010, 6'($urandom), 1'($urandom), 0, 0);
      idle_check("wrap");
      checks++;
      if (ret4 !== 4'b0001) $display("FAIL wrap_w4 got %b want 0001", ret4); else passed++;
   endtask

   task automatic test_random();
      logic [5:0] ops [6];
      logic [5:0] fns [5];
      logic [5:0] o, f;
      ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      for (int n = 0; n < 80; n++) begin
         o = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
         f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
         run_instr(o, f, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
      end
      idle_check("random");
   endtask

   initial begin
      rst_n = 1'b0; op = '0; funct = '0; zero = 1'b0; mr = 1'b0;
      test_reset();
      test_rtype();
      test_lw_stall();
      test_beq();
      test_illegal();
      test_reset_mid_sw();
      test_jump_disabled();
      test_wrap();
      test_reset();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired after %0d checks", checks);
      $fatal(1, "timeout");
   end

endmodule : tb_multicycle_control
`default_nettype wire
